// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
//   Round-robin arbiter that shares one Wishbone bus among NUM_MASTERS masters.
//   It issues a registered one-hot grant and holds it for the whole cycle, while the owner's
//   cyc stays high. Between owners it inserts one idle turnaround cycle.
//
// Ports
//   clk_i          bus clock; all logic on the rising edge
//   rst_i          synchronous reset, active-high
//   cyc_i          per-master cyc request
//   gnt_o          one-hot grant; all-zero when the bus is idle
//   gnt_idx_o      index of the current owner; valid when busy_o=1
//   busy_o         bus owned by some master
//   timeout_err_o  1-cycle pulse on forced release (tied 0 without WB_ARB_TIMEOUT_EN)
//
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the hold-time watchdog. With it, a
// master holding the bus for TIMEOUT_CYCLES cycles is forced off. That master is then masked
// from arbitration until it drops cyc_i for at least one cycle.

module wb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_MASTERS-1:0]         cyc_i,
  output logic [NUM_MASTERS-1:0]         gnt_o,
  output logic [$clog2(NUM_MASTERS)-1:0] gnt_idx_o,
  output logic                           busy_o,
  output logic                           timeout_err_o
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {StIdle, StBusy, StTurn} state_e;

  state_e                 r_state, w_state_d;
  logic [NUM_MASTERS-1:0] r_gnt, w_gnt_d;
  logic [IdxW-1:0]        r_idx, w_idx_d;
  logic [IdxW-1:0]        r_last, w_last_d;
  logic                   r_busy, w_busy_d;
  logic [NUM_MASTERS-1:0] w_req;
  logic [IdxW-1:0]        w_pick;
  logic                   w_found;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0]        r_cnt, w_cnt_d;
  logic [NUM_MASTERS-1:0] r_mask, w_mask_d;
  logic                   r_tmo, w_tmo_d;

  assign w_req = cyc_i & ~r_mask;
`else
  assign w_req = cyc_i;
`endif

  // Search upward from last_owner+1 with wrap-around. As a result, the master that released
  // most recently is examined last.
  always_comb begin
    int unsigned w_sum;
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      w_sum = 32'(r_last) + k;
      if (w_sum >= NUM_MASTERS) begin
        w_sum = w_sum - NUM_MASTERS;
      end
      if (!w_found && w_req[w_sum]) begin
        w_found = 1'b1;
        w_pick  = IdxW'(w_sum);
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_idx_d   = r_idx;
    w_last_d  = r_last;
    w_busy_d  = r_busy;
`ifdef WB_ARB_TIMEOUT_EN
    w_cnt_d   = r_cnt;
    w_tmo_d   = 1'b0;
    // A mask bit clears once its master has been seen with cyc low.
    w_mask_d  = r_mask & cyc_i;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_gnt_d         = '0;
          w_gnt_d[w_pick] = 1'b1;
          w_idx_d         = w_pick;
          w_busy_d        = 1'b1;
          w_state_d       = StBusy;
`ifdef WB_ARB_TIMEOUT_EN
          w_cnt_d         = '0;
`endif
        end
      end
      StBusy: begin
        if (!cyc_i[r_idx]) begin
          w_gnt_d   = '0;
          w_busy_d  = 1'b0;
          w_last_d  = r_idx;
          w_state_d = StTurn;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
          w_gnt_d         = '0;
          w_busy_d        = 1'b0;
          w_last_d        = r_idx;
          w_tmo_d         = 1'b1;
          w_mask_d[r_idx] = 1'b1;
          w_state_d       = StTurn;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
`endif
      end
      StTurn: begin
        // Dead cycle: requests are not looked at here.
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_gnt_d   = '0;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_last  <= IdxW'(NUM_MASTERS - 1);
      r_busy  <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_mask  <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_idx   <= w_idx_d;
      r_last  <= w_last_d;
      r_busy  <= w_busy_d;
`ifdef WB_ARB_TIMEOUT_EN
      r_cnt   <= w_cnt_d;
      r_mask  <= w_mask_d;
      r_tmo   <= w_tmo_d;
`endif
    end
  end

  assign gnt_o     = r_gnt;
  assign gnt_idx_o = r_idx;
  assign busy_o    = r_busy;
`ifdef WB_ARB_TIMEOUT_EN
  assign timeout_err_o = r_tmo;
`else
  assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter (4 masters). A transaction-level model tracks the owner, the
// last owner, the remaining dead cycles, the hold time and the mask. Outputs are compared on
// every cycle, and directed sequences pin literal grant values.
module tb_wb_bus_arbiter;
  localparam int N = 4;
  localparam int T = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] cyc;
  logic [N-1:0] gnt;
  logic [1:0]   gidx;
  logic         busy;
  logic         tmo;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (T)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cyc_i         (cyc),
    .gnt_o         (gnt),
    .gnt_idx_o     (gidx),
    .busy_o        (busy),
    .timeout_err_o (tmo)
  );

  // Model: owner index (-1 = none), last owner, dead-cycle flag, cycles held, mask.
  int           m_owner;
  int           m_last;
  int           m_idx;
  int           m_held;
  bit           m_dead;
  bit           m_tmo;
  bit [N-1:0]   m_mask;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input logic [N-1:0] c);
    logic [N-1:0] elig;
    if (r) begin
      m_owner = -1; m_last = N - 1; m_idx = 0; m_held = 0;
      m_dead  = 1'b0; m_tmo = 1'b0; m_mask = '0;
      return;
    end
    m_tmo  = 1'b0;
    elig   = c & ~m_mask;
    m_mask = m_mask & c;
    if (m_owner >= 0) begin
      if (!c[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_dead = 1'b1;
      end else begin
        m_held++;
        if (TE && m_held == T) begin
          m_tmo = 1'b1; m_mask[m_owner] = 1'b1;
          m_last = m_owner; m_owner = -1; m_dead = 1'b1;
        end
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (elig[i]) begin
          m_owner = i; m_idx = i; m_held = 0;
          break;
        end
      end
    end
  endtask

  // Drive at the falling edge, let the DUT and model see the rising edge, compare at the next
  // falling edge.
  task automatic step(input bit r, input logic [N-1:0] c);
    logic [N-1:0] eg;
    rst = r;
    cyc = c;
    @(posedge clk);
    model_step(r, c);
    @(negedge clk);
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("timeout_err", 32'(tmo), 32'(m_tmo));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (r || m_owner >= 0) chk("gnt_idx", 32'(gidx), 32'(m_idx));
  endtask

  task automatic lit(input string nm, input logic [N-1:0] exp);
    chk(nm, 32'(gnt), 32'(exp));
  endtask

  logic [N-1:0] rc;
  bit           rr;

  initial begin
    rst = 1'b1;
    cyc = '0;

    // Reset with requests pending, then master 0 wins first.
    step(1'b1, 4'b0011); lit("t1_rst0", 4'b0000); chk("t1_busy", 32'(busy), 32'd0);
    step(1'b1, 4'b0011); lit("t1_rst1", 4'b0000);
    step(1'b0, 4'b0011); lit("t1_first", 4'b0001);
    step(1'b0, 4'b0000); lit("t1_turn", 4'b0000);
    step(1'b0, 4'b0000);

    // Single master, 5 request cycles, then the turnaround.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0001); lit("t2_hold", 4'b0001);
    end
    step(1'b0, 4'b0000); lit("t2_rel", 4'b0000);
    step(1'b0, 4'b0000); lit("t2_turn", 4'b0000);

    // All masters requesting: rotation 1,2,3,0,1 with a 2-cycle gap after each owner.
    for (int o = 0; o < 5; o++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[(o + 1) % N] = 1'b1;
      for (int h = 0; h < 4; h++) begin
        step(1'b0, 4'b1111); lit("t3_rot", oh);
      end
      step(1'b0, 4'b1111 & ~oh); lit("t3_gap0", 4'b0000);
      step(1'b0, 4'b1111);       lit("t3_gap1", 4'b0000);
    end

    // Last owner 1, then 1010: master 3 is served first, then master 1.
    step(1'b0, 4'b0010); lit("t4_m1", 4'b0010);
    step(1'b0, 4'b0000); lit("t4_rel", 4'b0000);
    step(1'b0, 4'b1010); lit("t4_turn", 4'b0000);
    step(1'b0, 4'b1010); lit("t4_m3", 4'b1000);
    step(1'b0, 4'b1010); lit("t4_m3h", 4'b1000);
    step(1'b0, 4'b0010); lit("t4_rel3", 4'b0000);
    step(1'b0, 4'b0010); lit("t4_turn3", 4'b0000);
    step(1'b0, 4'b0010); lit("t4_m1b", 4'b0010);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    // Reset in the middle of BUSY.
    step(1'b0, 4'b0100); lit("t5_m2", 4'b0100);
    step(1'b0, 4'b0100); lit("t5_m2h", 4'b0100);
    step(1'b1, 4'b0100); lit("t5_rst", 4'b0000); chk("t5_tmo", 32'(tmo), 32'd0);
    step(1'b0, 4'b0011); lit("t5_m0", 4'b0001);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);

    if (TE) begin
      // Master 0 holds too long; master 1 is served; master 0 stays masked until cyc drops.
      step(1'b1, 4'b0000);
      for (int i = 0; i < T; i++) begin
        step(1'b0, 4'b0011); lit("t6_hold", 4'b0001);
      end
      step(1'b0, 4'b0011); lit("t6_drop", 4'b0000); chk("t6_pulse", 32'(tmo), 32'd1);
      step(1'b0, 4'b0011); lit("t6_turn", 4'b0000); chk("t6_pulse_end", 32'(tmo), 32'd0);
      step(1'b0, 4'b0011); lit("t6_m1", 4'b0010);
      step(1'b0, 4'b0001); lit("t6_rel1", 4'b0000);
      step(1'b0, 4'b0001); lit("t6_turn1", 4'b0000);
      step(1'b0, 4'b0001); lit("t6_masked", 4'b0000);
      step(1'b0, 4'b0000); lit("t6_unmask", 4'b0000);
      step(1'b0, 4'b0001); lit("t6_m0", 4'b0001);
    end

    // Random traffic: sticky per-master requests with occasional resets.
    rc = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) rc[b] = ~rc[b];
      end
      rr = ($urandom_range(199) == 0);
      step(rr, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
